// File: rtl/sccb_responder.sv
// rtl/sccb_responder.sv - SCCB slave (camera side) with register write/read target interface
//
// Purpose: decodes SCCB START/STOP, device ID, sub-address and data from an
//          oversampled SIO_C/SIO_D pair; supports 3-phase write and
//          2-phase write + 2-phase read; drives SIO_D open-drain style.
// Ports:
//   CLK, RST      system clock, synchronous active-high reset
//   i_sio_c       SCCB clock line (resolved bus level)
//   i_sio_d       SCCB data line (resolved bus level)
//   o_sio_d_low   1 = pull SIO_D low, 0 = release
//   o_rd_addr     sub-address latched by the last matched write phase
//   i_rd_data     register value for o_rd_addr, sampled at read-byte load
//   o_wr_valid    one-CLK pulse marking a completed write
//   o_wr_addr     sub-address of the completed write
//   o_wr_data     data byte of the completed write
//   o_busy        high from START until STOP/abort
module sccb_responder #(
   parameter logic [7:0] DeviceAddress = 8'h42,
   parameter int         SyncStages    = 2,
   parameter bit         DriveAck      = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       i_sio_c,
   input  logic       i_sio_d,
   output logic       o_sio_d_low,
   output logic [7:0] o_rd_addr,
   input  logic [7:0] i_rd_data,
   output logic       o_wr_valid,
   output logic [7:0] o_wr_addr,
   output logic [7:0] o_wr_data,
   output logic       o_busy
);

   typedef enum logic [3:0] {
      IDLE, ID, ID_ACK, SUB, SUB_ACK, DATA, DATA_ACK, RD_BYTE, RD_NA, IGNORE
   } state_t;

   localparam logic ACK_LOW = DriveAck;

   logic [SyncStages-1:0] c_sync;
   logic [SyncStages-1:0] d_sync;
   logic                  c_q;
   logic                  d_q;
   logic                  c_s;
   logic                  d_s;
   logic                  c_rise;
   logic                  c_fall;
   logic                  start_ev;
   logic                  stop_ev;

   state_t     state;
   logic [3:0] bit_cnt;
   logic [7:0] rx_sh;
   logic [7:0] tx_sh;
   logic       id_rd;

   // Synchronizers reset to 1 (idle bus level) so reset release cannot fake an edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         c_sync <= '1;
         d_sync <= '1;
         c_q    <= 1'b1;
         d_q    <= 1'b1;
      end else begin
         c_sync <= {c_sync[SyncStages-2:0], i_sio_c};
         d_sync <= {d_sync[SyncStages-2:0], i_sio_d};
         c_q    <= c_s;
         d_q    <= d_s;
      end
   end

   assign c_s      = c_sync[SyncStages-1];
   assign d_s      = d_sync[SyncStages-1];
   assign c_rise   =  c_s & ~c_q;
   assign c_fall   = ~c_s &  c_q;
   assign start_ev =  c_s &  d_q & ~d_s;
   assign stop_ev  =  c_s & ~d_q &  d_s;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         bit_cnt     <= 4'd0;
         rx_sh       <= 8'd0;
         tx_sh       <= 8'd0;
         id_rd       <= 1'b0;
         o_sio_d_low <= 1'b0;
         o_rd_addr   <= 8'd0;
         o_wr_valid  <= 1'b0;
         o_wr_addr   <= 8'd0;
         o_wr_data   <= 8'd0;
         o_busy      <= 1'b0;
      end else begin
         o_wr_valid <= 1'b0;
         // START/STOP take priority; a SIO_C edge coinciding with START is dropped.
         if (start_ev) begin
            state       <= ID;
            bit_cnt     <= 4'd0;
            o_busy      <= 1'b1;
            o_sio_d_low <= 1'b0;
         end else if (stop_ev) begin
            state       <= IDLE;
            o_busy      <= 1'b0;
            o_sio_d_low <= 1'b0;
         end else if (c_rise) begin
            if ((state == ID || state == SUB || state == DATA) && bit_cnt != 4'd8) begin
               rx_sh   <= {rx_sh[6:0], d_s};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (c_fall) begin
            case (state)
               ID: begin
                  if (bit_cnt == 4'd8) begin
                     if (rx_sh[7:1] == DeviceAddress[7:1]) begin
                        state       <= ID_ACK;
                        id_rd       <= rx_sh[0];
                        o_sio_d_low <= ACK_LOW;
                     end else begin
                        state       <= IGNORE;
                        o_sio_d_low <= 1'b0;
                     end
                  end
               end
               ID_ACK: begin
                  if (id_rd) begin
                     // First read bit goes out on the same edge that ends the ack.
                     state       <= RD_BYTE;
                     o_sio_d_low <= ~i_rd_data[7];
                     tx_sh       <= {i_rd_data[6:0], 1'b0};
                     bit_cnt     <= 4'd1;
                  end else begin
                     state       <= SUB;
                     o_sio_d_low <= 1'b0;
                     bit_cnt     <= 4'd0;
                  end
               end
               SUB: begin
                  if (bit_cnt == 4'd8) begin
                     state       <= SUB_ACK;
                     o_rd_addr   <= rx_sh;
                     o_sio_d_low <= ACK_LOW;
                  end
               end
               SUB_ACK: begin
                  state       <= DATA;
                  o_sio_d_low <= 1'b0;
                  bit_cnt     <= 4'd0;
               end
               DATA: begin
                  if (bit_cnt == 4'd8) begin
                     state       <= DATA_ACK;
                     o_wr_valid  <= 1'b1;
                     o_wr_addr   <= o_rd_addr;
                     o_wr_data   <= rx_sh;
                     o_sio_d_low <= ACK_LOW;
                  end
               end
               DATA_ACK: begin
                  state       <= IGNORE;
                  o_sio_d_low <= 1'b0;
               end
               RD_BYTE: begin
                  if (bit_cnt == 4'd8) begin
                     state       <= RD_NA;
                     o_sio_d_low <= 1'b0;
                  end else begin
                     o_sio_d_low <= ~tx_sh[7];
                     tx_sh       <= {tx_sh[6:0], 1'b0};
                     bit_cnt     <= bit_cnt + 4'd1;
                  end
               end
               RD_NA: begin
                  state       <= IGNORE;
                  o_sio_d_low <= 1'b0;
               end
               default: begin
                  o_sio_d_low <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
